// File: rtl/tff_counter.sv
// Bank of WIDTH toggle flip-flops usable as a modulo up/down counter or a raw
// per-bit toggle register, with synchronous preset/clear/load and wrap/tc flags.
module tff_counter #(
    parameter int WIDTH      = 4,
    parameter int MODULUS    = 16,
    parameter int PRESET_VAL = MODULUS - 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             pre,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_t;

    // One extra bit so MODULUS == 2**WIDTH is representable in the compares.
    localparam logic [WIDTH:0]   MOD_EXT    = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] PRESET     = WIDTH'(PRESET_VAL);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             live_reg;      // low until the first edge after reset release

    logic [WIDTH-1:0] toggle_r;
    logic [WIDTH-1:0] load_sat;
    logic             toggle_over;
    logic             at_max;
    logic             at_zero;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_toggle
            assign toggle_r[gi] = q_reg[gi] ^ t[gi];
        end
    endgenerate

    assign toggle_over = ({1'b0, toggle_r} >= MOD_EXT);
    assign load_sat    = ({1'b0, d} >= MOD_EXT) ? MAX_VAL : d;
    assign at_max      = (q_reg == MAX_VAL);
    assign at_zero     = (q_reg == '0);

    always_comb begin
        q_next    = q_reg;
        wrap_next = 1'b0;
        if (pre) begin
            q_next = PRESET;
        end else if (clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = load_sat;
        end else if (en) begin
            case (mode)
                MODE_UP: begin
                    if (at_max) begin
                        q_next    = '0;
                        wrap_next = 1'b1;
                    end else begin
                        q_next = q_reg + ONE;
                    end
                end
                MODE_DOWN: begin
                    if (at_zero) begin
                        q_next    = MAX_VAL;
                        wrap_next = 1'b1;
                    end else begin
                        q_next = q_reg - ONE;
                    end
                end
                MODE_TOGGLE: begin
                    if (toggle_over) begin
                        q_next    = '0;
                        wrap_next = 1'b1;
                    end else begin
                        q_next = toggle_r;
                    end
                end
                default: q_next = q_reg;
            endcase
        end
    end

    // The release edge only arms the bank; state stays at reset for that edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_reg    <= '0;
            wrap_reg <= 1'b0;
            live_reg <= 1'b0;
        end else if (!live_reg) begin
            live_reg <= 1'b1;
            wrap_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
        end
    end

    assign q    = q_reg;
    assign qbar = ~q_reg;
    assign wrap = wrap_reg;
    assign tc   = en & (((mode == MODE_UP) & at_max) | ((mode == MODE_DOWN) & at_zero));

endmodule

// File: tb/tb_tff_counter.sv
// Scoreboard bench for tff_counter (WIDTH=4, MODULUS=10): the driver queues hand-computed
// expectations, a monitor pops them at each falling edge (or on demand) and compares.
module tb_tff_counter;
    localparam int W = 4;
    localparam int M = 10;

    logic         clk   = 1'b0;
    logic         clr_n = 1'b0;
    logic         pre   = 1'b0;
    logic         clr   = 1'b0;
    logic         load  = 1'b0;
    logic         en    = 1'b0;
    logic [W-1:0] d     = '0;
    logic [W-1:0] t     = '0;
    logic [1:0]   mode  = 2'b00;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         tc;
    logic         wrap;

    typedef struct {
        string        name;
        logic [W-1:0] q;
        logic         tc;
        logic         wrap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event sample_now;

    tff_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk(clk), .clr_n(clr_n), .pre(pre), .clr(clr), .load(load), .d(d),
        .en(en), .mode(mode), .t(t), .q(q), .qbar(qbar), .tc(tc), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check1(input string nm, input string fld, input logic [W-1:0] act,
                          input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: every falling edge (and any on-demand sample) consumes one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_now);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check1(e.name, "q", q, e.q);
                check1(e.name, "qbar", qbar, ~e.q);
                check1(e.name, "tc", {{(W-1){1'b0}}, tc}, {{(W-1){1'b0}}, e.tc});
                check1(e.name, "wrap", {{(W-1){1'b0}}, wrap}, {{(W-1){1'b0}}, e.wrap});
                $display("%0t %-10s q=%h tc=%b wrap=%b (exp q=%h tc=%b wrap=%b)",
                         $time, e.name, q, tc, wrap, e.q, e.tc, e.wrap);
            end
        end
    end

    task automatic push(input string nm, input logic [W-1:0] eq, input logic etc, input logic ew);
        exp_t e;
        e.name = nm; e.q = eq; e.tc = etc; e.wrap = ew;
        sb.push_back(e);
    endtask

    // Apply inputs, take one rising edge, queue the expected state seen after it.
    task automatic cyc(input string nm, input logic p, input logic c, input logic l,
                       input logic [W-1:0] dd, input logic e, input logic [1:0] m,
                       input logic [W-1:0] tt, input logic [W-1:0] eq, input logic etc,
                       input logic ew);
        pre = p; clr = c; load = l; d = dd; en = e; mode = m; t = tt;
        @(posedge clk);
        push(nm, eq, etc, ew);
        @(negedge clk);
        #1;
    endtask

    // Short asynchronous reset pulse between edges; checked while still asserted.
    task automatic pulse_reset(input string nm);
        pre = 0; clr = 0; load = 0; en = 0; mode = 2'b00; t = '0; d = '0;
        clr_n = 1'b0;
        #1;
        push(nm, '0, 1'b0, 1'b0);
        -> sample_now;
        #1;
        clr_n = 1'b1;
    endtask

    initial begin
        #2;
        push("reset", '0, 1'b0, 1'b0);
        -> sample_now;
        @(negedge clk);
        #1;
        clr_n = 1'b1;

        // Reset release edge is a no-op even with an up-count requested.
        cyc("rel_noop", 0,0,0, 4'd0, 1,2'b01, 4'd0,  4'd0, 0,0);
        cyc("ld5",      0,0,1, 4'd5, 0,2'b00, 4'd0,  4'd5, 0,0);
        pulse_reset("rst_mid");
        cyc("rel1",     0,0,0, 4'd0, 1,2'b01, 4'd0,  4'd0, 0,0);
        for (int i = 0; i < 3; i++)
            cyc("idle",  0,0,0, 4'd0, 0,2'b01, 4'd0,  4'd0, 0,0);

        // Up count 0 -> 1..9,0,1,2
        for (int i = 1; i <= 12; i++)
            cyc("up", 0,0,0, 4'd0, 1,2'b01, 4'd0, W'(i % M), (i % M) == 9, i == 10);

        // Pending wrap pulse aborted by asynchronous reset
        cyc("ld9",      0,0,1, 4'd9, 0,2'b00, 4'd0,  4'd9, 0,0);
        cyc("up_wrap",  0,0,0, 4'd0, 1,2'b01, 4'd0,  4'd0, 0,1);
        pulse_reset("rst_wrap");
        cyc("rel2",     0,0,0, 4'd0, 0,2'b00, 4'd0,  4'd0, 0,0);

        // Down count from 1
        cyc("ld1",      0,0,1, 4'd1, 0,2'b00, 4'd0,  4'd1, 0,0);
        cyc("dn0",      0,0,0, 4'd0, 1,2'b10, 4'd0,  4'd0, 1,0);
        cyc("dn9",      0,0,0, 4'd0, 1,2'b10, 4'd0,  4'd9, 0,1);
        cyc("dn8",      0,0,0, 4'd0, 1,2'b10, 4'd0,  4'd8, 0,0);

        // Raw toggle mode
        cyc("clr",      0,1,0, 4'd0, 0,2'b00, 4'd0,  4'd0, 0,0);
        cyc("tg5",      0,0,0, 4'd0, 1,2'b11, 4'd5,  4'd5, 0,0);
        cyc("tg0",      0,0,0, 4'd0, 1,2'b11, 4'd5,  4'd0, 0,0);
        cyc("tg_hold",  0,0,0, 4'd0, 1,2'b11, 4'd0,  4'd0, 0,0);
        cyc("ld9b",     0,0,1, 4'd9, 0,2'b00, 4'd0,  4'd9, 0,0);
        cyc("tg_r15",   0,0,0, 4'd0, 1,2'b11, 4'd6,  4'd0, 0,1);
        cyc("ld8",      0,0,1, 4'd8, 0,2'b00, 4'd0,  4'd8, 0,0);
        cyc("tg_r10",   0,0,0, 4'd0, 1,2'b11, 4'd2,  4'd0, 0,1);
        cyc("tg_r3",    0,0,0, 4'd0, 1,2'b11, 4'd3,  4'd3, 0,0);

        // Priority and load saturation
        cyc("pre_all",  1,1,1, 4'd3, 0,2'b00, 4'd0,  4'd9, 0,0);
        cyc("ld12_en",  0,0,1, 4'd12,1,2'b01, 4'd0,  4'd9, 1,0);
        cyc("clr_at9",  0,1,0, 4'd0, 1,2'b01, 4'd0,  4'd0, 0,0);
        cyc("ld10",     0,0,1, 4'd10,0,2'b00, 4'd0,  4'd9, 0,0);
        cyc("clr_ld",   0,1,1, 4'd7, 0,2'b00, 4'd0,  4'd0, 0,0);

        // Up count with en toggling every other cycle
        cyc("en1",      0,0,0, 4'd0, 1,2'b01, 4'd0,  4'd1, 0,0);
        cyc("en0",      0,0,0, 4'd0, 0,2'b01, 4'd0,  4'd1, 0,0);
        cyc("en1",      0,0,0, 4'd0, 1,2'b01, 4'd0,  4'd2, 0,0);
        cyc("en0",      0,0,0, 4'd0, 0,2'b01, 4'd0,  4'd2, 0,0);
        cyc("en1",      0,0,0, 4'd0, 1,2'b01, 4'd0,  4'd3, 0,0);
        cyc("en0",      0,0,0, 4'd0, 0,2'b01, 4'd0,  4'd3, 0,0);

        // Mode changes mid-count act on the same edge
        cyc("mc_dn",    0,0,0, 4'd0, 1,2'b10, 4'd0,  4'd2, 0,0);
        cyc("mc_hold",  0,0,0, 4'd0, 1,2'b00, 4'd0,  4'd2, 0,0);
        cyc("mc_tog",   0,0,0, 4'd0, 1,2'b11, 4'd1,  4'd3, 0,0);

        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end
endmodule
